// File: rtl/branch_resolve_unit_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_if
// Bundles the prediction, resolution and training-update signals of the
// branch resolve unit.
//   master : producer of predictions/resolutions, consumer of updates
//   slave  : the resolve unit itself
// Signals:
//   pred_valid/pred_ready/pred_pc/pred_taken/local_pred/global_pred - predictions
//   res_valid/res_ea                                                 - resolutions
//   upd_valid/upd_pc/upd_taken/upd_mispredict/upd_local_ok/
//   upd_global_ok/flush                                              - training update
// -----------------------------------------------------------------------------
interface branch_resolve_unit_if #(
   parameter int ADDR_W = 5
);
   logic              pred_valid;
   logic              pred_ready;
   logic [ADDR_W-1:0] pred_pc;
   logic              pred_taken;
   logic              local_pred;
   logic              global_pred;
   logic              res_valid;
   logic [ADDR_W-1:0] res_ea;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic              upd_taken;
   logic              upd_mispredict;
   logic              upd_local_ok;
   logic              upd_global_ok;
   logic              flush;

   modport master (
      output pred_valid, pred_pc, pred_taken, local_pred, global_pred,
      output res_valid, res_ea,
      input  pred_ready,
      input  upd_valid, upd_pc, upd_taken, upd_mispredict, upd_local_ok,
      input  upd_global_ok, flush
   );

   modport slave (
      input  pred_valid, pred_pc, pred_taken, local_pred, global_pred,
      input  res_valid, res_ea,
      output pred_ready,
      output upd_valid, upd_pc, upd_taken, upd_mispredict, upd_local_ok,
      output upd_global_ok, flush
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolution side of a tournament branch predictor. Predictions are kept in an
// in-order in-flight queue; when the oldest branch resolves, the actual outcome
// (backward target = taken) is compared with the stored predictions and a
// one-cycle registered training update is produced. A misprediction flushes
// every younger in-flight entry. Saturating statistics are kept.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   bus (slave)       - prediction / resolution / update handshake
//   occupancy         - number of in-flight entries
//   branch_count      - resolved branches (saturating)
//   mispredict_count  - mispredictions (saturating)
//   underflow_err     - sticky: resolution seen with an empty queue
// The bus interface must be instantiated with the same ADDR_W as this module.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   branch_resolve_unit_if.slave      bus,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic [CNT_W-1:0]          branch_count,
   output logic [CNT_W-1:0]          mispredict_count,
   output logic                      underflow_err
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic              taken;
      logic              local_p;
      logic              global_p;
   } entry_t;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      logic [CNT_W-1:0] r;
      if (en && (v != {CNT_W{1'b1}})) begin
         r = v + CNT_W'(1);
      end else begin
         r = v;
      end
      return r;
   endfunction

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              upd_valid_q, upd_valid_d;
   logic [ADDR_W-1:0] upd_pc_q, upd_pc_d;
   logic              upd_taken_q, upd_taken_d;
   logic              upd_mis_q, upd_mis_d;
   logic              upd_lok_q, upd_lok_d;
   logic              upd_gok_q, upd_gok_d;
   logic              flush_q, flush_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
   logic              uflow_q, uflow_d;

   entry_t head_s;
   entry_t new_s;
   logic   empty_s, full_s, actual_s, pop_s, mis_s, push_s;

   // Queue status, outcome of the head branch and push/pop decisions.
   always_comb begin
      head_s   = mem_q[head_q];
      new_s    = '{pc: bus.pred_pc, taken: bus.pred_taken,
                   local_p: bus.local_pred, global_p: bus.global_pred};
      empty_s  = (occ_q == OCC_W'(0));
      full_s   = (occ_q == OCC_W'(DEPTH));
      actual_s = (bus.res_ea < head_s.pc);
      pop_s    = bus.res_valid && !empty_s;
      mis_s    = pop_s && (head_s.taken != actual_s);
      // A push while full is only legal when the head leaves on the same edge;
      // a same-cycle push is younger than a mispredicting head and is dropped.
      push_s   = bus.pred_valid && (!full_s || pop_s) && !mis_s;
   end

   // Next state for queue storage, pointers, update fields and statistics.
   always_comb begin
      mem_d       = mem_q;
      head_d      = head_q;
      tail_d      = tail_q;
      occ_d       = occ_q;
      upd_valid_d = pop_s;
      upd_pc_d    = upd_pc_q;
      upd_taken_d = upd_taken_q;
      upd_mis_d   = upd_mis_q;
      upd_lok_d   = upd_lok_q;
      upd_gok_d   = upd_gok_q;
      flush_d     = mis_s;
      br_cnt_d    = sat_inc(br_cnt_q, pop_s);
      mis_cnt_d   = sat_inc(mis_cnt_q, mis_s);
      uflow_d     = uflow_q | (bus.res_valid & empty_s);

      if (push_s) begin
         mem_d[tail_q] = new_s;
      end else begin
         mem_d[tail_q] = mem_q[tail_q];
      end

      if (mis_s) begin
         // Discard everything still in flight; restart the queue at the tail.
         head_d = tail_q;
         tail_d = tail_q;
         occ_d  = OCC_W'(0);
      end else begin
         head_d = pop_s  ? (head_q + PTR_W'(1)) : head_q;
         tail_d = push_s ? (tail_q + PTR_W'(1)) : tail_q;
         occ_d  = occ_q + (push_s ? OCC_W'(1) : OCC_W'(0))
                        - (pop_s  ? OCC_W'(1) : OCC_W'(0));
      end

      if (pop_s) begin
         upd_pc_d    = head_s.pc;
         upd_taken_d = actual_s;
         upd_mis_d   = mis_s;
         upd_lok_d   = (head_s.local_p == actual_s);
         upd_gok_d   = (head_s.global_p == actual_s);
      end else begin
         upd_pc_d    = upd_pc_q;
         upd_taken_d = upd_taken_q;
         upd_mis_d   = upd_mis_q;
         upd_lok_d   = upd_lok_q;
         upd_gok_d   = upd_gok_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         occ_q       <= '0;
         upd_valid_q <= 1'b0;
         upd_pc_q    <= '0;
         upd_taken_q <= 1'b0;
         upd_mis_q   <= 1'b0;
         upd_lok_q   <= 1'b0;
         upd_gok_q   <= 1'b0;
         flush_q     <= 1'b0;
         br_cnt_q    <= '0;
         mis_cnt_q   <= '0;
         uflow_q     <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         head_q      <= head_d;
         tail_q      <= tail_d;
         occ_q       <= occ_d;
         upd_valid_q <= upd_valid_d;
         upd_pc_q    <= upd_pc_d;
         upd_taken_q <= upd_taken_d;
         upd_mis_q   <= upd_mis_d;
         upd_lok_q   <= upd_lok_d;
         upd_gok_q   <= upd_gok_d;
         flush_q     <= flush_d;
         br_cnt_q    <= br_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
         uflow_q     <= uflow_d;
      end
   end

   assign bus.pred_ready     = !full_s;
   assign bus.upd_valid      = upd_valid_q;
   assign bus.upd_pc         = upd_pc_q;
   assign bus.upd_taken      = upd_taken_q;
   assign bus.upd_mispredict = upd_mis_q;
   assign bus.upd_local_ok   = upd_lok_q;
   assign bus.upd_global_ok  = upd_gok_q;
   assign bus.flush          = flush_q;
   assign occupancy          = occ_q;
   assign branch_count       = br_cnt_q;
   assign mispredict_count   = mis_cnt_q;
   assign underflow_err      = uflow_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed stimulus with hand-computed expected updates pushed into a
// scoreboard; a negedge monitor pops and compares whenever upd_valid is high.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_unit_if #(.ADDR_W(5)) ifa ();
   branch_resolve_unit_if #(.ADDR_W(5)) ifb ();

   assign ifb.pred_valid  = ifa.pred_valid;
   assign ifb.pred_pc     = ifa.pred_pc;
   assign ifb.pred_taken  = ifa.pred_taken;
   assign ifb.local_pred  = ifa.local_pred;
   assign ifb.global_pred = ifa.global_pred;
   assign ifb.res_valid   = ifa.res_valid;
   assign ifb.res_ea      = ifa.res_ea;

   logic [2:0] occ_a, occ_b;
   logic [7:0] bc_a, mc_a;
   logic [1:0] bc_b, mc_b;
   logic       uf_a, uf_b;

   branch_resolve_unit #(.ADDR_W(5), .DEPTH(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa), .occupancy(occ_a),
      .branch_count(bc_a), .mispredict_count(mc_a), .underflow_err(uf_a));

   branch_resolve_unit #(.ADDR_W(5), .DEPTH(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb), .occupancy(occ_b),
      .branch_count(bc_b), .mispredict_count(mc_b), .underflow_err(uf_b));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         due;
      logic [4:0] pc;
      logic       t, m, l, g;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every presented update against the scoreboard head.
   always @(negedge clk) begin
      if (ifa.upd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL upd_unexpected: got update pc=%0d expected none (t=%0t)",
                     ifa.upd_pc, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("upd_cycle",      cyc,                mon_e.due);
            chk("upd_pc",         ifa.upd_pc,         mon_e.pc);
            chk("upd_taken",      ifa.upd_taken,      mon_e.t);
            chk("upd_mispredict", ifa.upd_mispredict, mon_e.m);
            chk("upd_local_ok",   ifa.upd_local_ok,   mon_e.l);
            chk("upd_global_ok",  ifa.upd_global_ok,  mon_e.g);
            chk("flush",          ifa.flush,          mon_e.m);
         end
      end else begin
         chk("flush_idle", ifa.flush, 1'b0);
         if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL upd_missing: got no update expected pc=%0d at cycle %0d",
                     sb[0].pc, sb[0].due);
            void'(sb.pop_front());
         end
      end
   end

   // One clock of stimulus; inputs change 1ns after the edge.
   task automatic drive(input logic pv, input logic [4:0] pc, input logic pt,
                        input logic lp, input logic gp, input logic rv,
                        input logic [4:0] ea);
      ifa.pred_valid  = pv;
      ifa.pred_pc     = pc;
      ifa.pred_taken  = pt;
      ifa.local_pred  = lp;
      ifa.global_pred = gp;
      ifa.res_valid   = rv;
      ifa.res_ea      = ea;
      @(posedge clk);
      #1;
      ifa.pred_valid  = 1'b0;
      ifa.pred_pc     = 5'd0;
      ifa.pred_taken  = 1'b0;
      ifa.local_pred  = 1'b0;
      ifa.global_pred = 1'b0;
      ifa.res_valid   = 1'b0;
      ifa.res_ea      = 5'd0;
   endtask

   task automatic push(input logic [4:0] pc, input logic pt, input logic lp, input logic gp);
      drive(1'b1, pc, pt, lp, gp, 1'b0, 5'd0);
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Expected update for a resolve issued on the coming edge.
   task automatic add_exp(input logic [4:0] pc, input logic t, input logic m,
                          input logic l, input logic g);
      exp_t e;
      e.due = cyc + 1;
      e.pc = pc; e.t = t; e.m = m; e.l = l; e.g = g;
      sb.push_back(e);
   endtask

   task automatic resolve(input logic [4:0] ea);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ea);
   endtask

   logic [4:0] ea_tab [5];
   logic       tk;

   initial begin
      ea_tab[0] = 5'd9; ea_tab[1] = 5'd16; ea_tab[2] = 5'd9;
      ea_tab[3] = 5'd9; ea_tab[4] = 5'd16;
      ifa.pred_valid = 1'b0; ifa.pred_pc = 5'd0; ifa.pred_taken = 1'b0;
      ifa.local_pred = 1'b0; ifa.global_pred = 1'b0;
      ifa.res_valid = 1'b0; ifa.res_ea = 5'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      chk("rst_occupancy", occ_a, 3'd0);
      chk("rst_pred_ready", ifa.pred_ready, 1'b1);
      chk("rst_upd_valid", ifa.upd_valid, 1'b0);
      chk("rst_branch_count", bc_a, 8'd0);
      chk("rst_mispredict_count", mc_a, 8'd0);
      chk("rst_underflow", uf_a, 1'b0);

      // 1: PC 12, pred T, local T, global NT; outcomes T NT T T NT
      for (int i = 0; i < 5; i++) begin
         push(5'd12, 1'b1, 1'b1, 1'b0);
         tk = (ea_tab[i] == 5'd9);
         add_exp(5'd12, tk, !tk, tk, !tk);
         resolve(ea_tab[i]);
         chk("t1_occupancy", occ_a, 3'd0);
      end
      idle();
      chk("t1_branch_count", bc_a, 8'd5);
      chk("t1_mispredict_count", mc_a, 8'd2);
      chk("t1_branch_count_sat", bc_b, 2'd3);
      chk("t1_mispredict_count_b", mc_b, 2'd2);

      // 2: fill, drop a push while full, drain in order
      for (int i = 0; i < 4; i++) push(5'd12 + 5'(i), 1'b1, 1'b1, 1'b0);
      chk("t2_occupancy_full", occ_a, 3'd4);
      chk("t2_pred_ready_full", ifa.pred_ready, 1'b0);
      push(5'd7, 1'b0, 1'b0, 1'b0);
      chk("t2_occupancy_drop", occ_a, 3'd4);
      for (int i = 0; i < 4; i++) begin
         add_exp(5'd12 + 5'(i), 1'b1, 1'b0, 1'b1, 1'b0);
         resolve(5'd9);
      end
      chk("t2_occupancy_empty", occ_a, 3'd0);
      idle();

      // 3: mispredict flushes younger entries and a same-cycle push
      push(5'd12, 1'b1, 1'b1, 1'b0);
      push(5'd13, 1'b1, 1'b1, 1'b0);
      push(5'd14, 1'b1, 1'b1, 1'b0);
      add_exp(5'd12, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 5'd16);
      chk("t3_occupancy_flushed", occ_a, 3'd0);
      idle();
      push(5'd25, 1'b0, 1'b0, 1'b0);
      add_exp(5'd25, 1'b0, 1'b0, 1'b1, 1'b1);
      resolve(5'd30);
      chk("t3_occupancy_after", occ_a, 3'd0);
      idle();

      // 4: full queue, simultaneous push and correct resolve
      for (int i = 0; i < 4; i++) push(5'd12 + 5'(i), 1'b1, 1'b1, 1'b0);
      add_exp(5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
      chk("t4_occupancy_stays", occ_a, 3'd4);
      for (int i = 1; i < 4; i++) begin
         add_exp(5'd12 + 5'(i), 1'b1, 1'b0, 1'b1, 1'b0);
         resolve(5'd9);
      end
      add_exp(5'd16, 1'b1, 1'b0, 1'b0, 1'b1);
      resolve(5'd9);
      chk("t4_occupancy_empty", occ_a, 3'd0);
      idle();

      // 5: resolve with empty queue
      resolve(5'd9);
      chk("t5_underflow_set", uf_a, 1'b1);
      repeat (3) idle();
      chk("t5_underflow_sticky", uf_a, 1'b1);
      push(5'd12, 1'b1, 1'b1, 1'b0);
      add_exp(5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
      resolve(5'd9);
      idle();
      chk("t5_underflow_still", uf_a, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5_underflow_cleared", uf_a, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 6: saturation of the 2-bit counters, then mid-stream reset
      for (int i = 0; i < 5; i++) begin
         push(5'd12, 1'b1, 1'b1, 1'b0);
         add_exp(5'd12, 1'b0, 1'b1, 1'b0, 1'b1);
         resolve(5'd16);
      end
      idle();
      chk("t6_mispredict_sat_b", mc_b, 2'd3);
      chk("t6_branch_sat_b", bc_b, 2'd3);
      chk("t6_mispredict_count_a", mc_a, 8'd5);
      chk("t6_branch_count_a", bc_a, 8'd5);
      push(5'd12, 1'b1, 1'b1, 1'b0);
      push(5'd13, 1'b1, 1'b1, 1'b0);
      resolve(5'd9);          // update is pending now; reset discards it
      rst_n = 1'b0;
      #1;
      chk("t6_rst_upd_valid", ifa.upd_valid, 1'b0);
      chk("t6_rst_upd_pc", ifa.upd_pc, 5'd0);
      chk("t6_rst_upd_taken", ifa.upd_taken, 1'b0);
      chk("t6_rst_flush", ifa.flush, 1'b0);
      chk("t6_rst_occupancy", occ_a, 3'd0);
      chk("t6_rst_pred_ready", ifa.pred_ready, 1'b1);
      chk("t6_rst_branch_count", bc_a, 8'd0);
      chk("t6_rst_mispredict_count", mc_a, 8'd0);
      chk("t6_rst_mispredict_b", mc_b, 2'd0);
      chk("t6_rst_occupancy_b", occ_b, 3'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) idle();
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
